// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: opcode and divider state enums, result constants,
// and the single radix-2 restoring-division step used by the divider.
package rv32m_pkg;

   localparam int RV_XLEN = 32;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_CALC  = 2'b01,
      ST_FIXUP = 2'b10
   } div_state_e;

   localparam logic [RV_XLEN-1:0] DIV_BY_ZERO_Q = {RV_XLEN{1'b1}};
   localparam logic [RV_XLEN-1:0] SIGNED_MIN    = {1'b1, {(RV_XLEN-1){1'b0}}};

   typedef struct packed {
      logic [RV_XLEN-1:0] rem;
      logic [RV_XLEN-1:0] quo;
   } div_step_t;

   // The shifted partial remainder can exceed XLEN bits when the divisor has its
   // MSB set, so the trial subtract is one bit wider and its borrow decides the bit.
   function automatic div_step_t divStep(input logic [RV_XLEN-1:0] rem,
                                         input logic [RV_XLEN-1:0] dvd,
                                         input logic [RV_XLEN-1:0] dvsr);
      logic [RV_XLEN:0] shifted;
      logic [RV_XLEN:0] diff;
      div_step_t        res;
      shifted = {rem, dvd[RV_XLEN-1]};
      diff    = shifted - {1'b0, dvsr};
      res.quo = {dvd[RV_XLEN-2:0], ~diff[RV_XLEN]};
      res.rem = diff[RV_XLEN] ? shifted[RV_XLEN-1:0] : diff[RV_XLEN-1:0];
      return res;
   endfunction

endpackage

// File: rtl/divider_iterative.sv
// Multi-cycle RV32M divide unit (DIV/DIVU/REM/REMU), restoring radix-2,
// one quotient bit per cycle, with a start/ready handshake shared with the multiplier.
module divider_iterative
   import rv32m_pkg::*;
#(
   parameter int XLEN  = RV_XLEN,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            startE,
   input  logic [1:0]      div_opcode,
   input  logic [XLEN-1:0] operand1,
   input  logic [XLEN-1:0] operand2,
   output logic [XLEN-1:0] result_divide,
   output logic            ready,
   output logic            busy
);

   div_state_e       r_state;
   div_op_e          r_op;
   logic [XLEN-1:0]  r_rem;
   logic [XLEN-1:0]  r_dvd;
   logic [XLEN-1:0]  r_dvsr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_signQ;
   logic             r_signR;
   logic [XLEN-1:0]  r_result;
   logic             r_ready;
   logic             r_busy;

   logic             w_signedOp;
   logic             w_isRem;
   logic             w_s1;
   logic             w_s2;
   logic [XLEN-1:0]  w_abs1;
   logic [XLEN-1:0]  w_abs2;
   logic             w_divZero;
   logic             w_overflow;
   div_step_t        w_step;
   logic [XLEN-1:0]  w_quoFix;
   logic [XLEN-1:0]  w_remFix;

   // Opcode bit 0 selects unsigned, bit 1 selects remainder.
   assign w_signedOp = ~div_opcode[0];
   assign w_isRem    = div_opcode[1];
   assign w_s1       = w_signedOp & operand1[XLEN-1];
   assign w_s2       = w_signedOp & operand2[XLEN-1];
   assign w_abs1     = w_s1 ? -operand1 : operand1;
   assign w_abs2     = w_s2 ? -operand2 : operand2;
   assign w_divZero  = (operand2 == '0);
   assign w_overflow = w_signedOp && (operand1 == SIGNED_MIN) && (operand2 == '1);

   assign w_step   = divStep(r_rem, r_dvd, r_dvsr);
   assign w_quoFix = r_signQ ? -r_dvd : r_dvd;
   assign w_remFix = r_signR ? -r_rem : r_rem;

   // r_dvd doubles as the quotient: dividend bits shift out the top while
   // quotient bits shift in at the bottom, so after XLEN steps it holds the quotient.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_op     <= OP_DIV;
         r_rem    <= '0;
         r_dvd    <= '0;
         r_dvsr   <= '0;
         r_cnt    <= '0;
         r_signQ  <= 1'b0;
         r_signR  <= 1'b0;
         r_result <= '0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (startE) begin
                  r_op <= div_op_e'(div_opcode);
                  if (w_divZero) begin
                     r_result <= w_isRem ? operand1 : DIV_BY_ZERO_Q;
                     r_ready  <= 1'b1;
                  end else if (w_overflow) begin
                     r_result <= w_isRem ? '0 : SIGNED_MIN;
                     r_ready  <= 1'b1;
                  end else begin
                     r_dvd   <= w_abs1;
                     r_dvsr  <= w_abs2;
                     r_signQ <= w_s1 ^ w_s2;
                     r_signR <= w_s1;
                     r_rem   <= '0;
                     r_cnt   <= '0;
                     r_busy  <= 1'b1;
                     r_state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               r_rem <= w_step.rem;
               r_dvd <= w_step.quo;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(XLEN-1)) begin
                  r_state <= ST_FIXUP;
               end
            end
            ST_FIXUP: begin
               r_result <= ((r_op == OP_REM) || (r_op == OP_REMU)) ? w_remFix : w_quoFix;
               r_ready  <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign result_divide = r_result;
   assign ready         = r_ready;
   assign busy          = r_busy;

endmodule

// File: tb/tb_divider_iterative.sv
// Self-checking bench for divider_iterative: an arithmetic reference model with a
// cycle-count timing model, directed RISC-V corner cases and randomized operations.
module tb_divider_iterative;

   logic        clk;
   logic        rst_n;
   logic        startE;
   logic [1:0]  div_opcode;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic [31:0] result_divide;
   logic        ready;
   logic        busy;

   int          nCompared   = 0;
   int          nMismatched = 0;
   int          cyc         = 0;
   int          startCyc    = 0;
   logic        checkEn     = 1'b0;

   int          mRemain  = 0;
   logic        mReady   = 1'b0;
   logic [31:0] mResult  = '0;
   logic [31:0] mPending = '0;

   divider_iterative #(.XLEN(32), .CNT_W(6)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .startE        (startE),
      .div_opcode    (div_opcode),
      .operand1      (operand1),
      .operand2      (operand2),
      .result_divide (result_divide),
      .ready         (ready),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always begin
      @(posedge clk);
      cyc++;
   end

   // RISC-V division semantics from plain 64-bit arithmetic; the wide type absorbs
   // the signed-overflow case naturally (quotient 2^31 wraps to 0x80000000, remainder 0).
   function automatic logic [31:0] refDiv(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint x;
      longint y;
      longint q;
      longint r;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         x = $signed(a);
         y = $signed(b);
      end else begin
         x = {32'd0, a};
         y = {32'd0, b};
      end
      q = x / y;
      r = x % y;
      return op[1] ? r[31:0] : q[31:0];
   endfunction

   function automatic bit isSpecial(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
      return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Timing model: special cases answer at the accepting edge, all others 33 edges later.
   always begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mRemain = 0;
         mReady  = 1'b0;
         mResult = '0;
      end else begin
         mReady = 1'b0;
         if (mRemain > 0) begin
            mRemain--;
            if (mRemain == 0) begin
               mReady  = 1'b1;
               mResult = mPending;
            end
         end else if (startE) begin
            if (isSpecial(div_opcode, operand1, operand2)) begin
               mResult = refDiv(div_opcode, operand1, operand2);
               mReady  = 1'b1;
            end else begin
               mPending = refDiv(div_opcode, operand1, operand2);
               mRemain  = 33;
            end
         end
      end
   end

   always begin
      @(negedge clk);
      if (checkEn) begin
         checkOutput("cyc_ready", {31'd0, ready}, {31'd0, mReady});
         checkOutput("cyc_busy", {31'd0, busy}, {31'd0, (mRemain > 0)});
         checkOutput("cyc_result", result_divide, mResult);
      end
   end

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      div_opcode = op;
      operand1   = a;
      operand2   = b;
      startE     = 1'b1;
      startCyc   = cyc;
      @(negedge clk);
      startE = 1'b0;
   endtask

   task automatic waitReady(input string name, input logic [31:0] exp, input int expLat);
      int guard;
      guard = 0;
      while (ready !== 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (ready !== 1'b1) begin
         checkOutput({name, "_timeout"}, {31'd0, ready}, 32'd1);
      end else begin
         checkOutput(name, result_divide, exp);
         if (expLat > 0) checkOutput({name, "_lat"}, 32'(cyc - startCyc), 32'(expLat));
      end
   endtask

   task automatic runDirected(input string name, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp, input int expLat);
      applyStimulus(op, a, b);
      waitReady(name, exp, expLat);
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      bit          sawReady;

      rst_n      = 1'b1;
      startE     = 1'b0;
      div_opcode = 2'b00;
      operand1   = '0;
      operand2   = '0;
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_result", result_divide, 32'd0);
      checkOutput("rst_ready", {31'd0, ready}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      checkEn = 1'b1;
      @(negedge clk);

      checkOutput("model_div", refDiv(2'b00, 32'd20, 32'd3), 32'd6);
      checkOutput("model_rem_neg", refDiv(2'b10, 32'hFFFF_FFEC, 32'd3), 32'hFFFF_FFFE);
      checkOutput("model_ovf", refDiv(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
      checkOutput("model_divu", refDiv(2'b01, 32'hFFFF_FFFF, 32'd2), 32'h7FFF_FFFF);

      runDirected("div_20_3", 2'b00, 32'd20, 32'd3, 32'd6, 34);
      @(negedge clk);
      checkOutput("ready_drops", {31'd0, ready}, 32'd0);
      runDirected("rem_m20_3", 2'b10, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34);
      runDirected("div_m20_3", 2'b00, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34);
      runDirected("divu_max_2", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34);
      runDirected("remu_max_2", 2'b11, 32'hFFFF_FFFF, 32'd2, 32'd1, 34);
      runDirected("div_m1_2", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'd0, 34);
      runDirected("div_by0", 2'b00, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
      runDirected("remu_by0", 2'b11, 32'd7, 32'd0, 32'd7, 1);
      runDirected("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      runDirected("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      runDirected("divu_bigdiv", 2'b01, 32'hFFFF_FFF0, 32'h8000_0001, 32'd1, 34);

      applyStimulus(2'b01, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      div_opcode = 2'b00;
      operand1   = 32'd1000;
      operand2   = 32'd3;
      startE     = 1'b1;
      @(negedge clk);
      startE = 1'b0;
      waitReady("ignored_start", 32'd14, 34);

      runDirected("b2b_first", 2'b01, 32'd50, 32'd5, 32'd10, 34);
      runDirected("b2b_second", 2'b00, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 34);

      applyStimulus(2'b00, 32'd1000, 32'd7);
      repeat (13) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_ready", {31'd0, ready}, 32'd0);
      checkOutput("abort_result", result_divide, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      sawReady = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (ready === 1'b1) sawReady = 1'b1;
      end
      checkOutput("abort_no_pulse", {31'd0, sawReady}, 32'd0);
      runDirected("after_abort", 2'b00, 32'd1000, 32'd7, 32'd142, 34);

      for (int i = 0; i < 200; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 9))
            0: begin a = $urandom; b = 32'd0; end
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin
               a = $urandom_range(0, 1000);
               b = $urandom_range(1, 50);
               if ($urandom_range(0, 1) == 1) a = -a;
               if ($urandom_range(0, 1) == 1) b = -b;
            end
            default: begin
               a = $urandom;
               b = $urandom >> $urandom_range(0, 31);
            end
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
         applyStimulus(op, a, b);
         if (!isSpecial(op, a, b) && $urandom_range(0, 1) == 1) begin
            repeat (3) begin
               startE     = 1'($urandom_range(0, 1));
               operand1   = $urandom;
               operand2   = $urandom;
               div_opcode = 2'($urandom_range(0, 3));
               @(negedge clk);
            end
            startE = 1'b0;
         end
         waitReady("rand", refDiv(op, a, b), isSpecial(op, a, b) ? 1 : 34);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
